div_iter: RTL and testbench
===========================

# div_iter

Iterative 32-bit radix-2 divider for DIV/DIVU, instantiated inside the EX stage alongside the hi/lo path. EX raises `stallreq_for_ex` while a divide is in flight. On completion it writes `result_o` into hi (remainder) and lo (quotient) through the existing hi/lo write-enable fields of the EX-to-MEM bus. The divider produces one quotient bit per cycle, behind a start/ready handshake with annul.

## Interface
- No parameters. Data width is fixed at 32.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-high reset.
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled with `start_i`.
- `opdata1_i`  in  32  dividend. Sampled with `start_i`.
- `opdata2_i`  in  32  divisor. Sampled with `start_i`.
- `start_i`  in  1  request. Held high by EX until it has consumed `ready_o`.
- `annul_i`  in  1  abort the current operation (flush).
- `result_o`  out  64  {remainder[63:32], quotient[31:0]}. Valid only while `ready_o`=1.
- `ready_o`  out  1  result valid.

## Operation
- States are FREE, BY_ZERO, ON and END. The reset state is FREE, with `result_o`=0 and `ready_o`=0.
- In FREE:
  - `annul_i`=1 → stay in FREE.
  - Otherwise, with `start_i`=1:
    - divisor = 0 → BY_ZERO;
    - divisor ≠ 0 → ON. Latch the operands and the sign mode, clear the iteration counter `cnt`, and load the working register.
- Working register is 65 bits. It is loaded with {32'b0, |dividend|, 1'b0} in signed mode, or the raw dividend in unsigned mode.
- ON, each cycle:
  - Compute the trial difference (upper 33 bits of the working register) minus {1'b0, |divisor|].
  - Negative → shift left, inserting 0.
  - Non-negative → replace the upper bits with the difference, then shift left, inserting 1.
  - Increment `cnt`.
- ON, on the cycle with `cnt`=31: perform the final iteration and transition to END. `result_o` is latched with sign fix-up:
  - quotient is negated when the operand signs differ (signed mode only);
  - remainder takes the sign of the dividend (signed mode only).
- BY_ZERO: next cycle → END with `result_o`=0.
- END: `ready_o`=1.
  - `start_i`=0 → FREE; `ready_o` falls.
  - `start_i`=1 → stay in END.
  - `result_o` holds its value after leaving END.
- `annul_i`=1 in ON, BY_ZERO or END → FREE on the next edge. `result_o` is unchanged and `ready_o` is 0.
- Arithmetic rules:
  - Absolute values are taken with a 32-bit two's-complement negate, so 0x80000000 maps to itself and is treated as unsigned 2^31.
  - The overflow case 0x80000000 / −1 wraps: quotient 0x80000000, remainder 0.
- Operand inputs are ignored after the start cycle. Changing them while in ON has no effect.

## Timing
- Call the cycle in which FREE samples `start_i`=1 cycle 0.
  - Divisor ≠ 0: ON spans cycles 1–32, and `ready_o`=1 from cycle 33.
  - Divisor = 0: BY_ZERO in cycle 1, `ready_o`=1 from cycle 2.
- `ready_o` and `result_o` are registered outputs; there is no combinational path from any input to them.
- `ready_o` deasserts one cycle after `start_i` is seen low in END.
- A new start can be accepted in the cycle after returning to FREE. There is no back-to-back acceptance in END.
- `rst` asserted in any state → FREE, with `result_o`=0, `ready_o`=0 and `cnt`=0 on the next edge. `rst` has priority over `annul_i`, which has priority over `start_i`.

## Structure
- Constants shared via `lib/defines.vh`:
  - state encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2 bits);
  - `DivResultReady` / `DivResultNotReady`;
  - `DivStart` / `DivStop`.
- Single module, no sub-modules. The module comprises the state register, the 6-bit `cnt`, the 65-bit working register, the latched sign flags, and a 33-bit subtractor.
- EX instantiates it. `stallreq_for_ex` = DIV/DIVU in EX && `ready_o`=0.

## Test plan
- DIVU 100 / 7 → `ready_o` rises in cycle 33; `result_o`=0x00000002_0000000E.
- DIV −7 / 2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, in cycle 33.
- DIV 0x80000000 / 0xFFFFFFFF → `result_o`=0x00000000_80000000. Also DIVU 0xFFFFFFFF / 1 → 0x00000000_FFFFFFFF.
- Divisor 0 (both modes) → `ready_o`=1 in cycle 2 with `result_o`=0. Change operands during ON of a normal divide → result unaffected.
- `annul_i` pulse in cycle 10 → FREE in cycle 11 and `ready_o` never rises. A following DIVU 9 / 3 returns 0x00000000_00000003 at its own cycle 33.
- Hold `start_i` 5 cycles past ready → `ready_o` stays 1 and the result is stable; drop `start_i` → `ready_o`=0 the next cycle. Assert `rst` mid-ON → outputs zero next cycle.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared state encodings, handshake levels and helpers for the iterative divider.
package div_iter_pkg;

  localparam int DataWidth = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Magnitude of an operand; in signed mode 0x80000000 maps to itself and is
  // then treated as unsigned 2^31 by the datapath.
  function automatic logic [DataWidth-1:0] abs32(input logic [DataWidth-1:0] value,
                                                 input logic signed_mode);
    if (signed_mode && value[DataWidth-1]) begin
      return ~value + 32'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// start/ready handshake with annul, result = {remainder, quotient}.
module div_iter
  import div_iter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state;
  logic [5:0]  cnt;
  logic [64:0] work;
  logic [31:0] divisor_abs;
  logic        signed_mode;
  logic        dividend_neg;
  logic        divisor_neg;

  logic [32:0] trial;
  logic [64:0] work_next;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  // One restoring step on the partial remainder, plus sign fix-up of the outcome.
  always_comb begin
    trial = work[64:32] - {1'b0, divisor_abs};
    if (trial[32]) begin
      work_next = {work[63:0], 1'b0};
    end else begin
      work_next = {trial[31:0], work[31:0], 1'b1};
    end
    quot_fix = work_next[31:0];
    rem_fix  = work_next[64:33];
    if (signed_mode && (dividend_neg ^ divisor_neg)) begin
      quot_fix = ~work_next[31:0] + 32'd1;
    end
    if (signed_mode && dividend_neg) begin
      rem_fix = ~work_next[64:33] + 32'd1;
    end
  end

  // Control FSM with datapath registers and registered result/ready outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DivFree;
      cnt          <= 6'd0;
      work         <= '0;
      divisor_abs  <= '0;
      signed_mode  <= 1'b0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      result_o     <= '0;
      ready_o      <= DivResultNotReady;
    end else begin
      case (state)
        DivFree: begin
          if (!annul_i && start_i == DivStart) begin
            if (opdata2_i == 32'd0) begin
              state <= DivByZero;
            end else begin
              state        <= DivOn;
              cnt          <= 6'd0;
              work         <= {32'b0, abs32(opdata1_i, signed_div_i), 1'b0};
              divisor_abs  <= abs32(opdata2_i, signed_div_i);
              signed_mode  <= signed_div_i;
              dividend_neg <= opdata1_i[31];
              divisor_neg  <= opdata2_i[31];
            end
          end
        end
        DivByZero: begin
          if (annul_i) begin
            state <= DivFree;
          end else begin
            state    <= DivEnd;
            result_o <= '0;
            ready_o  <= DivResultReady;
          end
        end
        DivOn: begin
          if (annul_i) begin
            state <= DivFree;
          end else begin
            work <= work_next;
            cnt  <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state    <= DivEnd;
              result_o <= {rem_fix, quot_fix};
              ready_o  <= DivResultReady;
            end
          end
        end
        DivEnd: begin
          if (annul_i || start_i == DivStop) begin
            state   <= DivFree;
            ready_o <= DivResultNotReady;
          end
        end
        default: begin
          state   <= DivFree;
          ready_o <= DivResultNotReady;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: transaction-level reference model compared
// every cycle, plus directed cases with literal results and ready latencies.
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  int checks = 0;
  int errors = 0;
  bit compare_en = 1'b0;

  div_iter dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div),
    .opdata1_i   (opdata1),
    .opdata2_i   (opdata2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic: DIV truncates toward zero, remainder follows dividend.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'b0, a};
      sb = {32'b0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h at %0t", name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: busy countdown, ready flag and held result.
  bit          m_busy = 1'b0;
  int          m_left = 0;
  bit          m_ready = 1'b0;
  logic [63:0] m_result = 64'd0;
  logic [63:0] m_pending = 64'd0;

  // Advance the model on every active edge from the same inputs the DUT sees.
  always @(posedge clk) begin
    if (rst) begin
      m_busy   = 1'b0;
      m_ready  = 1'b0;
      m_result = 64'd0;
    end else if (m_busy) begin
      if (annul) begin
        m_busy = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_busy   = 1'b0;
          m_ready  = 1'b1;
          m_result = m_pending;
        end
      end
    end else if (m_ready) begin
      if (annul || !start) m_ready = 1'b0;
    end else if (!annul && start) begin
      m_busy    = 1'b1;
      m_left    = (opdata2 == 32'd0) ? 1 : 32;
      m_pending = ref_div(opdata1, opdata2, signed_div);
    end
  end

  // Compare outputs against the model on the inactive edge of every cycle.
  always @(negedge clk) begin
    if (compare_en) begin
      check_output("cyc_ready", {63'd0, ready}, {63'd0, m_ready});
      check_output("cyc_result", result, m_result);
    end
  end

  // Issue one divide; returns the cycle in which ready was first seen (-1 if none).
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                input int annul_at, input int hold, input bit scramble,
                                output int ready_cyc);
    ready_cyc  = -1;
    opdata1    = a;
    opdata2    = b;
    signed_div = s;
    start      = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #2;
      if (scramble && c <= 3) begin
        opdata1    = $urandom;
        opdata2    = $urandom;
        signed_div = 1'($urandom_range(0, 1));
      end
      if (annul_at != 0 && c == annul_at) begin
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk); #2;
        annul = 1'b0;
        return;
      end
      if (ready) begin
        ready_cyc = c;
        break;
      end
    end
    repeat (hold) begin
      @(posedge clk); #2;
    end
    start = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp_res, input int exp_cyc);
    int cyc;
    apply_stimulus(a, b, s, 0, 0, 1'b0, cyc);
    check_output({name, "_cycle"}, 64'(cyc), 64'(exp_cyc));
    check_output({name, "_result"}, result, exp_res);
  endtask

  function automatic logic [31:0] pick_op(input bit divisor);
    case ($urandom_range(0, 7))
      0:       return divisor ? 32'd0 : 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int cyc;
    logic [31:0] a, b;
    logic s;
    int annul_at;

    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;

    // Hand-computed values pinning the reference model.
    check_output("pin_divu_100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h0000_0002_0000_000E);
    check_output("pin_div_m7_2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), 64'hFFFF_FFFF_FFFF_FFFD);
    check_output("pin_div_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), 64'h0000_0000_8000_0000);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    compare_en = 1'b1;
    check_output("reset_ready", {63'd0, ready}, 64'd0);
    check_output("reset_result", result, 64'd0);

    directed("divu_100_7", 32'd100, 32'd7, 1'b0, 64'h0000_0002_0000_000E, 33);
    directed("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    directed("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_8000_0000, 33);
    directed("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 33);
    directed("divu_by0", 32'd55, 32'd0, 1'b0, 64'd0, 2);
    directed("divu_1000_7", 32'd1000, 32'd7, 1'b0, 64'h0000_0006_0000_008E, 33);
    directed("div_by0", 32'hFFFF_FFF0, 32'd0, 1'b1, 64'd0, 2);

    // Operands wiggle during ON; the latched ones must still be used.
    apply_stimulus(32'd1000, 32'd7, 1'b0, 0, 0, 1'b1, cyc);
    check_output("scramble_cycle", 64'(cyc), 64'd33);
    check_output("scramble_result", result, 64'h0000_0006_0000_008E);

    // Annul in cycle 10, then a fresh DIVU 9/3.
    apply_stimulus(32'd12345, 32'd17, 1'b0, 10, 0, 1'b0, cyc);
    check_output("annul_ready_low", {63'd0, ready}, 64'd0);
    check_output("annul_result_held", result, 64'h0000_0006_0000_008E);
    directed("divu_9_3", 32'd9, 32'd3, 1'b0, 64'h0000_0000_0000_0003, 33);

    // Hold start past ready; ready must stay high until start drops.
    opdata1 = 32'd77; opdata2 = 32'd10; signed_div = 1'b0; start = 1'b1;
    cyc = -1;
    for (int c = 1; c <= 40 && cyc < 0; c++) begin
      @(posedge clk); #2;
      if (ready) cyc = c;
    end
    check_output("hold_cycle", 64'(cyc), 64'd33);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      check_output("hold_ready", {63'd0, ready}, 64'd1);
      check_output("hold_result", result, 64'h0000_0007_0000_0007);
    end
    start = 1'b0;
    @(posedge clk); #2;
    check_output("drop_ready", {63'd0, ready}, 64'd0);
    check_output("drop_result_held", result, 64'h0000_0007_0000_0007);

    // Reset in the middle of ON.
    opdata1 = 32'd500; opdata2 = 32'd3; start = 1'b1;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    check_output("midrst_ready", {63'd0, ready}, 64'd0);
    check_output("midrst_result", result, 64'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #2;

    // Randomized divides with occasional annul and random hold.
    for (int n = 0; n < 40; n++) begin
      a = pick_op(1'b0);
      b = pick_op(1'b1);
      s = 1'($urandom_range(0, 1));
      annul_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 34)) : 0;
      apply_stimulus(a, b, s, annul_at, int'($urandom_range(0, 3)), 1'b1, cyc);
      if (annul_at == 0) begin
        check_output("rand_cycle", 64'(cyc), (b == 32'd0) ? 64'd2 : 64'd33);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    @(posedge clk); #2;
    compare_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
